// File: rtl/lif_layer.sv
// Time-multiplexed leaky integrate-and-fire layer, one neuron per cycle.
// Define LIF_SPIKE_CNT_EN to add the saturating spike_cnt output.
module lif_layer #(
    parameter int N_NEURONS  = 4,
    parameter int WIDTH      = 8,
    parameter int LEAK_SHIFT = 1,
    parameter int REFRAC     = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       step_valid,
    output logic                       step_ready,
    input  logic [N_NEURONS*WIDTH-1:0] cur_in,
    input  logic [WIDTH-1:0]           thr,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [N_NEURONS-1:0]       spikes,
    output logic [N_NEURONS*WIDTH-1:0] mem_out
`ifdef LIF_SPIKE_CNT_EN
    ,
    output logic [15:0]                spike_cnt
`endif
);

    localparam int IW = (N_NEURONS > 1) ? $clog2(N_NEURONS) : 1;

    typedef enum logic [1:0] {IDLE, UPDATE, DONE} state_t;

    state_t                       state;
    logic [IW-1:0]                idx;
    logic [N_NEURONS*WIDTH-1:0]   cur_q;
    logic [WIDTH-1:0]             thr_q;
    logic [3:0]                   rc [N_NEURONS];

    logic [WIDTH-1:0]             v_cur;
    logic [WIDTH-1:0]             c_cur;
    logic [WIDTH-1:0]             leaked;
    logic [WIDTH:0]               sum;
    logic [WIDTH-1:0]             vn;
    logic                         refrac;
    logic                         fire;

    // mem_out doubles as the membrane store, so it always holds v
    always_comb begin
        v_cur  = mem_out[idx*WIDTH +: WIDTH];
        c_cur  = cur_q[idx*WIDTH +: WIDTH];
        leaked = v_cur - (v_cur >> LEAK_SHIFT);
        sum    = {1'b0, leaked} + {1'b0, c_cur};
        vn     = sum[WIDTH] ? {WIDTH{1'b1}} : sum[WIDTH-1:0];
        refrac = (rc[idx] != 4'd0);
        fire   = !refrac && (vn >= thr_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            step_ready <= 1'b1;
            out_valid  <= 1'b0;
            spikes     <= '0;
            mem_out    <= '0;
            idx        <= '0;
            cur_q      <= '0;
            thr_q      <= '0;
            for (int i = 0; i < N_NEURONS; i++) rc[i] <= 4'd0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (step_valid) begin
                        cur_q      <= cur_in;
                        thr_q      <= thr;
                        idx        <= '0;
                        step_ready <= 1'b0;
                        state      <= UPDATE;
                    end
                end
                UPDATE: begin
                    if (refrac) begin
                        rc[idx]                       <= rc[idx] - 4'd1;
                        mem_out[idx*WIDTH +: WIDTH]   <= '0;
                        spikes[idx]                   <= 1'b0;
                    end else if (fire) begin
                        rc[idx]                       <= 4'(REFRAC);
                        mem_out[idx*WIDTH +: WIDTH]   <= '0;
                        spikes[idx]                   <= 1'b1;
                    end else begin
                        mem_out[idx*WIDTH +: WIDTH]   <= vn;
                        spikes[idx]                   <= 1'b0;
                    end
                    if (idx == IW'(N_NEURONS - 1)) begin
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid  <= 1'b0;
                        step_ready <= 1'b1;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef LIF_SPIKE_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            spike_cnt <= 16'd0;
        end else if (state == UPDATE && fire && spike_cnt != 16'hFFFF) begin
            spike_cnt <= spike_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_lif_layer.sv
// Scoreboard bench for lif_layer: directed plan steps plus random steps.
// Spike counter checked when LIF_SPIKE_CNT_EN is defined.
module tb_lif_layer;

    localparam int N  = 4;
    localparam int W  = 8;
    localparam int LS = 1;
    localparam int RF = 2;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           step_valid = 1'b0;
    logic           step_ready;
    logic [N*W-1:0] cur_in = '0;
    logic [W-1:0]   thr = '0;
    logic           out_valid;
    logic           out_ready = 1'b1;
    logic [N-1:0]   spikes;
    logic [N*W-1:0] mem_out;
`ifdef LIF_SPIKE_CNT_EN
    logic [15:0]    spike_cnt;
`endif

    lif_layer #(
        .N_NEURONS (N),
        .WIDTH     (W),
        .LEAK_SHIFT(LS),
        .REFRAC    (RF)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .step_valid(step_valid),
        .step_ready(step_ready),
        .cur_in    (cur_in),
        .thr       (thr),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .spikes    (spikes),
        .mem_out   (mem_out)
`ifdef LIF_SPIKE_CNT_EN
        ,
        .spike_cnt (spike_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [N-1:0]   spk;
        logic [N*W-1:0] mem;
        int             cnt;
        longint         acc;
    } exp_t;

    exp_t   q[$];
    int     n_chk = 0;
    int     n_fail = 0;
    longint cyc = 0;
    bit     seen = 0;
    bit     rand_rdy = 0;
    bit     have_last = 0;
    longint last_acc = 0;

    int m_v [N];
    int m_rc [N];
    int m_cnt = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input longint act, input longint exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at cycle %0d", name, act, exp, cyc);
        end
    endtask

    function automatic void model_clear();
        for (int i = 0; i < N; i++) begin
            m_v[i]  = 0;
            m_rc[i] = 0;
        end
        m_cnt = 0;
    endfunction

    // Behavioural timestep: whole layer at once, plain integer arithmetic
    function automatic exp_t model_step(input logic [N*W-1:0] c, input int t);
        exp_t e;
        int   vmax = (1 << W) - 1;
        for (int i = 0; i < N; i++) begin
            int vn;
            e.spk[i] = 1'b0;
            if (m_rc[i] > 0) begin
                m_rc[i]--;
                m_v[i] = 0;
            end else begin
                vn = m_v[i] - (m_v[i] >> LS) + int'(c[i*W +: W]);
                if (vn > vmax) vn = vmax;
                if (vn >= t) begin
                    e.spk[i] = 1'b1;
                    m_v[i]   = 0;
                    m_rc[i]  = RF;
                    if (m_cnt < 65535) m_cnt++;
                end else begin
                    m_v[i] = vn;
                end
            end
            e.mem[i*W +: W] = W'(m_v[i]);
        end
        e.cnt = m_cnt;
        return e;
    endfunction

    task automatic chk_reset_vals();
        chk("rst_step_ready", step_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_spikes", spikes, 0);
        chk("rst_mem_out", mem_out, 0);
`ifdef LIF_SPIKE_CNT_EN
        chk("rst_spike_cnt", spike_cnt, 0);
`endif
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk_reset_vals();
        q.delete();
        seen      = 0;
        have_last = 0;
        model_clear();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic issue_step(input logic [N*W-1:0] c, input logic [W-1:0] t);
        int     w = 0;
        exp_t   e;
        longint acc;
        @(posedge clk);
        #1;
        step_valid = 1'b1;
        cur_in     = {$urandom, $urandom};
        thr        = W'($urandom);
        @(negedge clk);
        while (!step_ready && w < 100) begin
            w++;
            cur_in = {$urandom, $urandom};
            thr    = W'($urandom);
            @(negedge clk);
        end
        if (!step_ready) begin
            chk("accept_timeout", 0, 1);
            step_valid = 1'b0;
            return;
        end
        cur_in = c;
        thr    = t;
        acc    = cyc + 1;
        @(posedge clk);
        e     = model_step(c, int'(t));
        e.acc = acc;
        q.push_back(e);
        if (!rand_rdy && have_last) chk("step_spacing", acc - last_acc, N + 2);
        have_last = 1;
        last_acc  = acc;
        #1;
        step_valid = 1'b0;
        cur_in     = {$urandom, $urandom};
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            out_ready = rand_rdy ? ($urandom_range(0, 3) != 0) : 1'b1;
        end
    end

    always @(negedge clk) begin
        if (rst_n && out_valid) begin
            if (q.size() == 0) begin
                chk("unexpected_out_valid", 1, 0);
            end else begin
                if (!seen) begin
                    chk("latency", cyc, q[0].acc + N);
                    seen = 1;
                end
                chk("spikes", spikes, q[0].spk);
                chk("mem_out", mem_out, q[0].mem);
                chk("ready_while_valid", step_ready, 0);
`ifdef LIF_SPIKE_CNT_EN
                chk("spike_cnt", spike_cnt, q[0].cnt);
`endif
                if (out_ready) begin
                    void'(q.pop_front());
                    seen = 0;
                end
            end
        end
    end

    initial begin
        logic [N*W-1:0] c;
        int             w;
        model_clear();
        #12;
        chk_reset_vals();
        @(negedge clk);
        rst_n = 1'b1;

        for (int s = 0; s < 6; s++) begin
            c = '0;
            c[0 +: W] = W'(60);
            issue_step(c, W'(100));
        end

        do_reset();
        for (int s = 0; s < 2; s++) begin
            c = '0;
            c[W +: W] = W'(200);
            issue_step(c, W'(255));
        end

        do_reset();
        for (int s = 0; s < 4; s++) issue_step('0, W'(0));

        do_reset();
        rand_rdy = 1;
        for (int s = 0; s < 200; s++) begin
            for (int i = 0; i < N; i++)
                c[i*W +: W] = ($urandom_range(0, 1) != 0) ?
                              W'($urandom_range(0, 255)) :
                              W'($urandom_range(0, 40));
            issue_step(c, ($urandom_range(0, 9) == 0) ? W'(0) :
                          W'($urandom_range(0, 255)));
            if (s % 50 == 49) begin
                @(posedge clk);
                @(posedge clk);
                #1;
                rst_n = 1'b0;
                #1;
                chk_reset_vals();
                q.delete();
                seen      = 0;
                have_last = 0;
                model_clear();
                @(negedge clk);
                rst_n = 1'b1;
            end
        end

        w = 0;
        while (q.size() != 0 && w < 500) begin
            @(posedge clk);
            w++;
        end
        if (q.size() != 0) chk("drain_timeout", q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
